harmonic_scheduler: RTL and testbench

Time-multiplexes one shared sine ROM between the three harmonic phase accumulators of a note voice. Replaces three independent sine lookups with one ROM port. Sits between the note player, which supplies `step_size`, `weight` and the 48 kHz `generate_next_sample` strobe, and the voice mixer, which consumes `harmonic_out` and `sample_ready`.

---
 rtl/harmonic_scheduler_if.sv | 22 ++
 rtl/harmonic_scheduler.sv | 160 ++++++++++++++++
 tb/tb_harmonic_scheduler.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/harmonic_scheduler_if.sv
// Bus bundle between the note player / voice mixer side and harmonic_scheduler,
// including the shared sine ROM port.
interface harmonic_scheduler_if;
  logic               play_enable;
  logic               generate_next_sample;
  logic [19:0]        step_size;
  logic [1:0]         weight;
  logic [9:0]         rom_addr;
  logic [15:0]        rom_data;
  logic signed [17:0] harmonic_out;
  logic               sample_ready;

  modport master (
    output play_enable, generate_next_sample, step_size, weight, rom_data,
    input  rom_addr, harmonic_out, sample_ready
  );

  modport slave (
    input  play_enable, generate_next_sample, step_size, weight, rom_data,
    output rom_addr, harmonic_out, sample_ready
  );
endinterface

// File: rtl/harmonic_scheduler.sv
// Shares one quarter-wave sine ROM port between three harmonic phase accumulators.
// HARMONIC_SCHED_SHORT_EN: weight-0 samples skip the h2/h3 lookups (pulse at T+4).
//
// state | meaning
// IDLE  | waiting for trigger; phases advance on acceptance
// A1    | rom_addr shows harmonic 1
// A2    | rom_addr shows harmonic 2, capture s1
// A3    | rom_addr shows harmonic 3, capture s2
// D3    | capture s3
// D1    | short path only: capture s1
// SUM   | register weighted mix, pulse sample_ready
module harmonic_scheduler (
  input logic               clk,
  input logic               reset,
  harmonic_scheduler_if.slave bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] A1   = 3'd1;
  localparam logic [2:0] A2   = 3'd2;
  localparam logic [2:0] A3   = 3'd3;
  localparam logic [2:0] D3   = 3'd4;
  localparam logic [2:0] SUM  = 3'd5;
  localparam logic [2:0] D1   = 3'd6;

`ifdef HARMONIC_SCHED_SHORT_EN
  localparam logic SHORT_EN = 1'b1;
`else
  localparam logic SHORT_EN = 1'b0;
`endif

  logic [2:0]         state_q, state_d;
  logic [21:0]        p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic [1:0]         weight_q, weight_d;
  logic [9:0]         rom_addr_q, rom_addr_d;
  logic signed [17:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic signed [17:0] harmonic_out_q, harmonic_out_d;
  logic               sample_ready_q, sample_ready_d;

  logic               trigger;
  logic [21:0]        h1, p1_next, p2_next, p3_next;
  logic signed [17:0] mix;

  // Quadrant bit 0 mirrors the quarter-wave table.
  function automatic logic [9:0] addr_of(input logic [21:0] p);
    return p[20] ? ~p[19:10] : p[19:10];
  endfunction

  // Quadrant bit 1 selects the negative half of the wave.
  function automatic logic signed [17:0] to_sample(input logic neg, input logic [15:0] mag);
    logic signed [17:0] m;
    m = signed'({2'b00, mag});
    return neg ? -m : m;
  endfunction

  always_comb begin
    trigger = bus.generate_next_sample && bus.play_enable;
    h1      = {2'b00, bus.step_size};
    p1_next = p1_q + h1;
    p2_next = p2_q + (h1 << 1);
    p3_next = p3_q + (h1 << 2);

    case (weight_q)
      2'd0:    mix = s1_q;
      2'd1:    mix = (s1_q >>> 1) + (s1_q >>> 3) + (s2_q >>> 2) + (s2_q >>> 3);
      default: mix = (s1_q >>> 1) + (s1_q >>> 3) + (s2_q >>> 2) + (s3_q >>> 3);
    endcase
  end

  always_comb begin
    state_d        = state_q;
    p1_d           = p1_q;
    p2_d           = p2_q;
    p3_d           = p3_q;
    weight_d       = weight_q;
    rom_addr_d     = rom_addr_q;
    s1_d           = s1_q;
    s2_d           = s2_q;
    s3_d           = s3_q;
    harmonic_out_d = harmonic_out_q;
    sample_ready_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          p1_d       = p1_next;
          p2_d       = p2_next;
          p3_d       = p3_next;
          weight_d   = bus.weight;
          rom_addr_d = addr_of(p1_next);
          state_d    = A1;
        end
      end
      A1: begin
        if (SHORT_EN && weight_q == 2'd0) begin
          state_d = D1;
        end else begin
          rom_addr_d = addr_of(p2_q);
          state_d    = A2;
        end
      end
      D1: begin
        s1_d    = to_sample(p1_q[21], bus.rom_data);
        state_d = SUM;
      end
      A2: begin
        s1_d       = to_sample(p1_q[21], bus.rom_data);
        rom_addr_d = addr_of(p3_q);
        state_d    = A3;
      end
      A3: begin
        s2_d    = to_sample(p2_q[21], bus.rom_data);
        state_d = D3;
      end
      D3: begin
        s3_d    = to_sample(p3_q[21], bus.rom_data);
        state_d = SUM;
      end
      SUM: begin
        harmonic_out_d = mix;
        sample_ready_d = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      p1_q           <= '0;
      p2_q           <= '0;
      p3_q           <= '0;
      weight_q       <= '0;
      rom_addr_q     <= '0;
      s1_q           <= '0;
      s2_q           <= '0;
      s3_q           <= '0;
      harmonic_out_q <= '0;
      sample_ready_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      p1_q           <= p1_d;
      p2_q           <= p2_d;
      p3_q           <= p3_d;
      weight_q       <= weight_d;
      rom_addr_q     <= rom_addr_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      harmonic_out_q <= harmonic_out_d;
      sample_ready_q <= sample_ready_d;
    end
  end

  assign bus.rom_addr     = rom_addr_q;
  assign bus.harmonic_out = harmonic_out_q;
  assign bus.sample_ready = sample_ready_q;

endmodule

// File: tb/tb_harmonic_scheduler.sv
// Self-checking bench for harmonic_scheduler: directed vector table, hand-written
// corner sequences, and randomized triggers against a phase-arithmetic model.
module tb_harmonic_scheduler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  harmonic_scheduler_if hs_if ();

  harmonic_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hs_if.slave)
  );

`ifdef HARMONIC_SCHED_SHORT_EN
  localparam bit SHORT_EN = 1'b1;
`else
  localparam bit SHORT_EN = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int rom_mode = 0;
  int mp[3];

  function automatic logic [15:0] rom_f(input int mode, input logic [9:0] a);
    logic [15:0] x;
    x = {6'b0, a};
    case (mode)
      0:       return x;
      1:       return 16'h4000;
      default: return 16'((x * 16'd97) ^ 16'h1234 ^ (x << 5));
    endcase
  endfunction

  // Synchronous ROM: data follows the address by one cycle.
  always @(posedge clk) hs_if.rom_data <= rom_f(rom_mode, hs_if.rom_addr);

  function automatic logic [9:0] m_addr(input int p);
    int q0, a;
    q0 = (p >> 20) & 1;
    a  = (p >> 10) & 1023;
    return 10'((q0 != 0) ? (1023 - a) : a);
  endfunction

  function automatic int m_samp(input int p);
    int mag;
    mag = int'(rom_f(rom_mode, m_addr(p)));
    return (((p >> 21) & 1) != 0) ? -mag : mag;
  endfunction

  task automatic model_accept(input int step, input int w,
                              output logic [9:0] a1, output logic [9:0] a2,
                              output logic [9:0] a3, output logic [17:0] out,
                              output int lat, output bit short_path);
    int s1, s2, s3, o, we;
    for (int k = 0; k < 3; k++) mp[k] = (mp[k] + (step << k)) & 32'h3fffff;
    we = (w == 3) ? 2 : w;
    s1 = m_samp(mp[0]);
    s2 = m_samp(mp[1]);
    s3 = m_samp(mp[2]);
    if (we == 0)      o = s1;
    else if (we == 1) o = (s1 >>> 1) + (s1 >>> 3) + (s2 >>> 2) + (s2 >>> 3);
    else              o = (s1 >>> 1) + (s1 >>> 3) + (s2 >>> 2) + (s3 >>> 3);
    a1 = m_addr(mp[0]);
    a2 = m_addr(mp[1]);
    a3 = m_addr(mp[2]);
    out = 18'(o);
    short_path = SHORT_EN && (we == 0);
    lat = short_path ? 4 : 6;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hs_if.generate_next_sample = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) mp[k] = 0;
    cyc();
  endtask

  // Trigger in the current cycle T and watch T+1..T+lat, then one cycle past the pulse.
  task automatic run_seq(input logic [9:0] a1, input logic [9:0] a2, input logic [9:0] a3,
                         input logic [17:0] out, input int lat, input bit short_path,
                         input bit scramble);
    hs_if.generate_next_sample = 1'b1;
    for (int c = 1; c <= lat; c++) begin
      cyc();
      hs_if.generate_next_sample = 1'b0;
      if (scramble) begin
        hs_if.step_size   = 20'($urandom);
        hs_if.weight      = 2'($urandom);
        hs_if.play_enable = 1'($urandom);
      end
      if (c == 1) check("rom_addr_h1", {22'b0, hs_if.rom_addr}, {22'b0, a1});
      if (!short_path && c == 2) check("rom_addr_h2", {22'b0, hs_if.rom_addr}, {22'b0, a2});
      if (!short_path && c == 3) check("rom_addr_h3", {22'b0, hs_if.rom_addr}, {22'b0, a3});
      check("ready_timing", 32'(hs_if.sample_ready), 32'(c == lat));
      if (c == lat) check("harmonic_out", {14'b0, hs_if.harmonic_out}, {14'b0, out});
    end
    cyc();
    check("ready_single", 32'(hs_if.sample_ready), 32'd0);
  endtask

  typedef struct {
    logic [19:0] step;
    logic [1:0]  w;
    int          mode;
    int          ntrig;
    logic [9:0]  a1, a2, a3;
    logic [17:0] out;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [9:0]  a1, a2, a3, e2a1;
    logic [17:0] eo, eo2;
    int          lat, lat2, pulses;
    bit          sp, sp2;

    vt[0] = '{20'h00400, 2'd0, 0, 1, 10'd1,    10'd2, 10'd4, 18'd1};
    vt[1] = '{20'h00400, 2'd2, 1, 1, 10'd1,    10'd2, 10'd4, 18'd16384};
    vt[2] = '{20'h00400, 2'd1, 1, 1, 10'd1,    10'd2, 10'd4, 18'd16384};
    vt[3] = '{20'h80400, 2'd0, 0, 2, 10'd1021, 10'd4, 10'd8, 18'd1021};
    vt[4] = '{20'h80400, 2'd2, 0, 2, 10'd1021, 10'd4, 10'd8, 18'd637};
    vt[5] = '{20'h80400, 2'd1, 0, 2, 10'd1021, 10'd4, 10'd8, 18'd635};

    hs_if.play_enable          = 1'b0;
    hs_if.generate_next_sample = 1'b0;
    hs_if.step_size            = '0;
    hs_if.weight               = '0;
    #1;
    reset = 1'b1;
    cyc();
    cyc();
    check("rst_rom_addr", {22'b0, hs_if.rom_addr}, 32'd0);
    check("rst_out", {14'b0, hs_if.harmonic_out}, 32'd0);
    check("rst_ready", 32'(hs_if.sample_ready), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("idle_rom_addr", {22'b0, hs_if.rom_addr}, 32'd0);
      check("idle_out", {14'b0, hs_if.harmonic_out}, 32'd0);
      check("idle_ready", 32'(hs_if.sample_ready), 32'd0);
    end

    // Directed vectors, each from a fresh reset.
    for (int v = 0; v < 6; v++) begin
      rom_mode = vt[v].mode;
      do_reset();
      hs_if.step_size   = vt[v].step;
      hs_if.weight      = vt[v].w;
      hs_if.play_enable = 1'b1;
      for (int t = 0; t < vt[v].ntrig; t++) begin
        model_accept(int'(vt[v].step), int'(vt[v].w), a1, a2, a3, eo, lat, sp);
        if (t == vt[v].ntrig - 1)
          run_seq(vt[v].a1, vt[v].a2, vt[v].a3, vt[v].out, lat, sp, 1'b0);
        else
          run_seq(a1, a2, a3, eo, lat, sp, 1'b0);
      end
    end

    // Reset at T+3 aborts the sequence and clears phases.
    rom_mode = 0;
    do_reset();
    hs_if.step_size = 20'h00400; hs_if.weight = 2'd2; hs_if.play_enable = 1'b1;
    hs_if.generate_next_sample = 1'b1;
    cyc();
    hs_if.generate_next_sample = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) mp[k] = 0;
    check("abort_rom_addr", {22'b0, hs_if.rom_addr}, 32'd0);
    for (int c = 4; c <= 8; c++) begin
      check("abort_no_ready", 32'(hs_if.sample_ready), 32'd0);
      cyc();
    end
    model_accept(32'h400, 2, a1, a2, a3, eo, lat, sp);
    run_seq(a1, a2, a3, eo, lat, sp, 1'b0);

    // Trigger with play_enable low is dropped.
    hs_if.play_enable = 1'b0;
    hs_if.step_size = 20'h12345;
    hs_if.generate_next_sample = 1'b1;
    cyc();
    hs_if.generate_next_sample = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check("pe_low_ready", 32'(hs_if.sample_ready), 32'd0);
      check("pe_low_rom_addr", {22'b0, hs_if.rom_addr}, {22'b0, m_addr(mp[2])});
      cyc();
    end
    hs_if.play_enable = 1'b1;
    hs_if.step_size = 20'h00400;
    model_accept(32'h400, 2, a1, a2, a3, eo, lat, sp);
    run_seq(a1, a2, a3, eo, lat, sp, 1'b0);

    // Trigger at T+3 dropped, trigger at T+6 accepted.
    rom_mode = 2;
    hs_if.step_size = 20'h01a37; hs_if.weight = 2'd2;
    model_accept(32'h01a37, 2, a1, a2, a3, eo, lat, sp);
    e2a1 = '0; eo2 = '0; lat2 = 0; sp2 = 1'b0;
    pulses = 0;
    hs_if.generate_next_sample = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      hs_if.generate_next_sample = (c == 3 || c == 6);
      if (c == 6) model_accept(32'h01a37, 2, e2a1, a2, a3, eo2, lat2, sp2);
      if (hs_if.sample_ready === 1'b1) pulses++;
      check("b2b_ready", 32'(hs_if.sample_ready), 32'(c == 6 || c == 12));
      if (c == 6)  check("b2b_out1", {14'b0, hs_if.harmonic_out}, {14'b0, eo});
      if (c == 7)  check("b2b_addr2", {22'b0, hs_if.rom_addr}, {22'b0, e2a1});
      if (c == 12) check("b2b_out2", {14'b0, hs_if.harmonic_out}, {14'b0, eo2});
    end
    check("b2b_pulses", 32'(pulses), 32'd2);
    hs_if.generate_next_sample = 1'b0;
    cyc();

    // Randomized triggers with mid-sequence input scrambling.
    rom_mode = 2;
    do_reset();
    for (int i = 0; i < 150; i++) begin
      int gap;
      logic [19:0] st;
      logic [1:0]  w;
      gap = int'($urandom_range(0, 3));
      hs_if.play_enable = 1'b0;
      for (int g = 0; g < gap; g++) begin
        hs_if.step_size = 20'($urandom);
        hs_if.generate_next_sample = 1'($urandom);
        cyc();
        check("rnd_gap_ready", 32'(hs_if.sample_ready), 32'd0);
      end
      st = 20'($urandom);
      w  = 2'($urandom);
      hs_if.step_size   = st;
      hs_if.weight      = w;
      hs_if.play_enable = 1'b1;
      model_accept(int'(st), int'(w), a1, a2, a3, eo, lat, sp);
      run_seq(a1, a2, a3, eo, lat, sp, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
